// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {pc, instr, fault} with flush and fetch stall.
// Optional zero-latency empty-queue bypass is enabled by defining IF_ID_QUEUE_BYPASS_EN.
module if_id_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic [XLEN-1:0]         in_pc,
  input  logic [XLEN-1:0]         in_instr,
  input  logic                    in_fault,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [XLEN-1:0]         out_pc,
  output logic [XLEN-1:0]         out_instr,
  output logic                    out_fault,
  input  logic                    out_ready,
  output logic                    fetch_stall,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            fault;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          in_entry;
  entry_t          head;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  assign in_entry = '{pc: in_pc, instr: in_instr, fault: in_fault};
  assign head     = mem[rd_ptr];

  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign fetch_stall = full;
  // Flush drains any stale imem response, so the input is always open then.
  assign in_ready    = !full || flush;
  assign pop         = !empty && out_ready && !flush;

`ifdef IF_ID_QUEUE_BYPASS_EN
  logic bypass;
  logic bypass_taken;

  // An empty queue forwards the response straight to decode.
  assign bypass       = empty && in_valid && !flush;
  assign bypass_taken = bypass && out_ready;
  assign push         = in_valid && !full && !flush && !bypass_taken;
  assign out_valid    = (!empty || bypass) && !flush;

  always_comb begin
    out_pc    = head.pc;
    out_instr = head.instr;
    out_fault = head.fault;
    if (bypass) begin
      out_pc    = in_entry.pc;
      out_instr = in_entry.instr;
      out_fault = in_entry.fault;
    end
  end
`else
  assign push      = in_valid && !full && !flush;
  assign out_valid = !empty && !flush;

  always_comb begin
    out_pc    = head.pc;
    out_instr = head.instr;
    out_fault = head.fault;
  end
`endif

  // Pointer and occupancy tracking; flush returns everything to the origin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry storage, cleared on reset so the head read is never X.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= in_entry;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed scenarios plus random traffic checked by a queue-based scoreboard.
module tb_if_id_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned XLEN  = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            fault;
  } ent_t;

  logic clk = 1'b0;
  logic reset_n;
  logic flush;
  logic in_valid;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_instr;
  logic in_fault;
  logic in_ready;
  logic out_valid;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic out_fault;
  logic out_ready;
  logic fetch_stall;
  logic [$clog2(DEPTH):0] count;

  int tests = 0;
  int fails = 0;

  ent_t exp_q[$];
  ent_t head;
  int   sz;
  bit   byp;
  bit   exp_valid;
  bit   m_pop;
  bit   m_push;

  if_id_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_fault(in_fault),
    .in_ready(in_ready), .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_fault(out_fault), .out_ready(out_ready), .fetch_stall(fetch_stall), .count(count)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: compares DUT against the queue model mid-cycle, then advances the model.
  always @(negedge clk) begin
    if (!reset_n) begin
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_fetch_stall", 64'(fetch_stall), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      exp_q.delete();
    end else begin
      sz  = exp_q.size();
      byp = 1'b0;
`ifdef IF_ID_QUEUE_BYPASS_EN
      byp = (sz == 0) && in_valid && !flush;
`endif
      exp_valid = ((sz > 0) || byp) && !flush;
      check("count", 64'(count), 64'(sz));
      check("fetch_stall", 64'(fetch_stall), 64'(sz == int'(DEPTH)));
      check("in_ready", 64'((sz < int'(DEPTH)) || flush), 64'(in_ready) ^ 64'd0);
      check("out_valid", 64'(out_valid), 64'(exp_valid));
      if (exp_valid) begin
        head = byp ? ent_t'{pc: in_pc, instr: in_instr, fault: in_fault} : exp_q[0];
        check("out_pc", 64'(out_pc), 64'(head.pc));
        check("out_instr", 64'(out_instr), 64'(head.instr));
        check("out_fault", 64'(out_fault), 64'(head.fault));
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        m_pop  = (sz > 0) && out_ready;
        m_push = in_valid && (sz < int'(DEPTH)) && !(byp && out_ready);
        if (m_pop) void'(exp_q.pop_front());
        if (m_push) exp_q.push_back(ent_t'{pc: in_pc, instr: in_instr, fault: in_fault});
      end
    end
  end

  task automatic drive(input bit v, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] instr,
                       input bit f, input bit ordy, input bit fl);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = instr;
    in_fault  = f;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit ordy, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, ordy, 1'b0);
  endtask

  initial begin
    logic [XLEN-1:0] pc;
    bit ordy;
    bit acc;
    reset_n = 1'b0;
    flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; in_fault = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Single push, consumed on arrival.
    drive(1'b1, 32'h0, 32'h13, 1'b0, 1'b1, 1'b0);
    idle(1'b1, 2);

    // Fill with decode stalled, attempt a fifth, then drain in order.
    for (int i = 0; i < 4; i++) drive(1'b1, XLEN'(i * 4), XLEN'(32'h1000 + i), 1'(i == 2), 1'b0, 1'b0);
    drive(1'b1, 32'h10, 32'hBAD0, 1'b0, 1'b0, 1'b0);
    // Full with simultaneous push and pop: push refused, then accepted.
    drive(1'b1, 32'h10, 32'h1004, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 32'h10, 32'h1004, 1'b0, 1'b1, 1'b0);
    idle(1'b1, 5);

    // Wrap-around stream with decode ready toggling.
    pc = '0;
    ordy = 1'b1;
    while (pc <= 32'h24) begin
      acc = exp_q.size() < int'(DEPTH);
      drive(1'b1, pc, pc ^ 32'h5500_0000, 1'b0, ordy, 1'b0);
      if (acc) pc = pc + 32'h4;
      ordy = !ordy;
    end
    idle(1'b1, 6);

    // Flush with three queued and a stale response arriving.
    for (int i = 0; i < 3; i++) drive(1'b1, XLEN'(32'h200 + i * 4), XLEN'(i), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hDEAD, 32'hDEAD, 1'b1, 1'b1, 1'b1);
    idle(1'b1, 2);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 2; i++) drive(1'b1, XLEN'(32'h300 + i * 4), XLEN'(i), 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("async_out_valid", 64'(out_valid), 64'd0);
    check("async_count", 64'(count), 64'd0);
    check("async_fetch_stall", 64'(fetch_stall), 64'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    drive(1'b1, 32'h100, 32'h0000_0093, 1'b0, 1'b1, 1'b0);
    idle(1'b1, 2);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 1)), XLEN'($urandom), XLEN'($urandom), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
    idle(1'b1, 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Instruction queue directly downstream of the fetch stage.
- Captures instruction-memory responses (PC, instruction word, fault flag) and presents them in order to the decode stage over a valid/ready handshake.
- Decouples imem response timing from decode back-pressure.
- Drives the fetch stall input when it cannot accept more responses.
- Supports a pipeline flush on branch/exception redirect.

Parameters:
- DEPTH, 4, number of queue entries; power of two, >= 2.
- XLEN, 32, width of the PC and instruction fields.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- flush  input  1  discard all queued and incoming entries this cycle.
- in_valid  input  1  imem response valid.
- in_pc  input  XLEN  PC of the responding fetch.
- in_instr  input  XLEN  instruction word.
- in_fault  input  1  imem access fault for this fetch.
- in_ready  output  1  queue accepts a response this cycle.
- out_valid  output  1  entry available to decode.
- out_pc  output  XLEN  PC of the head entry.
- out_instr  output  XLEN  instruction of the head entry.
- out_fault  output  1  fault flag of the head entry.
- out_ready  input  1  decode consumes the head entry.
- fetch_stall  output  1  to fetch stall input; high when no further response can be accepted.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (reset_n low, asynchronous): rd_ptr = wr_ptr = 0, count = 0.
- Reset output values: out_valid 0, in_ready 1, fetch_stall 0, out_pc/out_instr 0, out_fault 0.
- Reset may assert mid-operation; all entries are lost immediately, with no partial handshakes.
- Storage: circular buffer of DEPTH entries, each {pc, instr, fault}.
  - rd_ptr and wr_ptr are $clog2(DEPTH) bits wide and wrap modulo DEPTH by natural overflow.
  - count is tracked separately so that full (count == DEPTH) and empty (count == 0) are unambiguous.
- Push: in_valid && in_ready && !flush writes the entry at wr_ptr; wr_ptr increments.
- Pop: out_valid && out_ready && !flush; rd_ptr increments.
- Occupancy update: count += push - pop.
- Simultaneous push and pop: count unchanged, both pointers advance.
- in_ready = !full.
  - When full, no push occurs even if a pop happens the same cycle; the slot becomes available the next cycle.
- fetch_stall = full. It is registered-equivalent: derived from count only, never from in_valid or out_ready combinationally.
- out_valid = !empty && !flush.
- out_pc/out_instr/out_fault are driven from the entry at rd_ptr.
  - They are stable while out_valid && !out_ready.
  - When empty, they hold the last read entry's value (don't-care, but X-free after reset).
- Latency (default build): a response pushed in cycle N is visible on out_* in cycle N+1.
- Flush (synchronous, highest priority):
  - In the flush cycle, in_ready is forced 1 and any in_valid response is accepted-and-dropped, so a stale imem response is drained.
  - out_valid is forced 0 during the flush cycle.
  - Next cycle: count = 0, rd_ptr = wr_ptr = 0.
  - Flush while full: same as above; fetch_stall deasserts the next cycle.
- Ordering: strict FIFO. Entries are never reordered or duplicated.
- A fault entry is queued like any other; the fault is the decoder's concern.

Optional Feature:
- Macro: IF_ID_QUEUE_BYPASS_EN.
- Defined:
  - When the queue is empty, in_valid && out_ready && !flush passes the input combinationally to out_* in the same cycle (zero latency) and nothing is written; count stays 0.
  - If out_ready is low, the input is stored as usual.
  - out_valid = (!empty || in_valid) && !flush.
- Undefined: no combinational path from in_* to out_*; minimum latency is one cycle as above.

Test Plan:
- Reset then single push (in_pc=0x0000_0000, in_instr=0x0000_0013) with out_ready=1:
  - out_valid rises the next cycle with out_pc=0, out_instr=0x13; count returns to 0 after pop.
  - With IF_ID_QUEUE_BYPASS_EN: out_valid rises in the same cycle, count stays 0.
- Fill with out_ready=0 and pushes at PCs 0x0,0x4,0x8,0xC:
  - count=4, fetch_stall=1, in_ready=0.
  - A 5th in_valid is not accepted.
  - Then out_ready=1: outputs appear in order 0x0,0x4,0x8,0xC, one per cycle.
- Full queue, simultaneous in_valid and out_ready in the same cycle:
  - Pop occurs, push refused; count goes 4→3.
  - The next cycle accepts the push; count stays 3 with simultaneous push/pop.
- Wrap-around: stream 10 entries (PCs 0x0–0x24) with out_ready toggling 1/0 each cycle:
  - All 10 are received in order with no loss or duplication; pointers wrap twice.
- Flush with 3 entries queued and in_valid=1 in the flush cycle:
  - out_valid=0 in the flush cycle; in_ready=1.
  - Next cycle count=0, out_valid=0, and the dropped response never appears.
- Async reset asserted mid-stream (count=2, between clock edges):
  - Immediately out_valid=0, count=0, fetch_stall=0.
  - After release, the first push at PC 0x100 is the first output.
